ladder_seq: RTL and testbench

//  Upstream sequencer for the three-core ECC point-multiplication array.

---
 rtl/ecc_pkg.sv | 23 ++
 rtl/ladder_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_ladder_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC point-multiplication sequencer.
// Holds the ladder FSM state type plus the default array geometry
// (scalar width, core count, restart guard and watchdog limit).
package ecc_pkg;

  // Default geometry of the three-core array.
  localparam int ECC_KW       = 163;
  localparam int ECC_NCORES   = 3;
  localparam int ECC_GUARD    = 3;
  localparam int ECC_WDOG_MAX = 1023;

  // Width of the bit index output; must hold KW-1.
  localparam int ECC_IDXW = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_RST  = 3'd2,
    S_RUN  = 3'd3,
    S_FIN  = 3'd4
  } ladder_state_t;

endpackage

// File: rtl/ladder_seq.sv
// ladder_seq: upstream sequencer for the three-core ECC point-multiplication array.
// Latches a scalar, scans it sequentially (one bit per cycle) for its leading one,
// then runs one ladder step per lower key bit, MSB to LSB: a 1-cycle core restart
// followed by an enabled run phase that lasts until every core reports done.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start, key      1-cycle request and scalar, accepted only while idle
//   core_done       per-core done levels, ANDed together
//   core_rst_n      active-low synchronous restart to the cores (high only in run phase)
//   core_enable     enable to every core pc (high only in run phase)
//   swap1, swap2    current key bit, stable for a whole step
//   bit_idx         index of the key bit being scanned/processed
//   busy, done      busy from accepted start through completion; 1-cycle done pulse
//   zero_key        with done: scalar was zero; held until the next accepted start
//   wdog_err        sticky run-phase timeout flag
// Build option: define LADDER_WDOG_EN to add the run-phase watchdog; without it
// wdog_err is tied low and the run phase waits for the cores indefinitely.
module ladder_seq
  import ecc_pkg::*;
#(
  parameter int KW       = ECC_KW,
  parameter int NCORES   = ECC_NCORES,
  parameter int GUARD    = ECC_GUARD,
  parameter int WDOG_MAX = ECC_WDOG_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     key,
  input  logic [NCORES-1:0] core_done,
  output logic              core_rst_n,
  output logic              core_enable,
  output logic              swap1,
  output logic              swap2,
  output logic [7:0]        bit_idx,
  output logic              busy,
  output logic              done,
  output logic              zero_key,
  output logic              wdog_err
);

  localparam int IDXW = ECC_IDXW;
  // Guard counter must be at least one bit wide even if GUARD is 0.
  localparam int GW   = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ladder_state_t   state_q, state_d;
  logic [KW-1:0]   key_q, key_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            zero_key_q, zero_key_d;
  logic            swap_q, swap_d;
  logic [GW-1:0]   guard_q, guard_d;

  logic cur_bit;
  logic all_done;
  logic idx_zero;

  // Key bit addressed by the current index; used by both the scan and the
  // restart cycle that captures the swap value for the upcoming step.
  assign cur_bit  = key_q[idx_q];
  assign all_done = &core_done;
  assign idx_zero = (idx_q == '0);

`ifdef LADDER_WDOG_EN
  localparam int WW = $clog2(WDOG_MAX + 1);

  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          wdog_err_q, wdog_err_d;
`else
  // Watchdog limit has no effect in this build.
  logic [31:0] unused_wdog_max;
  assign unused_wdog_max = WDOG_MAX;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    zero_key_d = zero_key_q;
    swap_d     = swap_q;
    guard_d    = guard_q;
`ifdef LADDER_WDOG_EN
    wcnt_d     = wcnt_q;
    wdog_err_d = wdog_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d      = key;
          idx_d      = IDXW'(KW - 1);
          busy_d     = 1'b1;
          zero_key_d = 1'b0;
          state_d    = S_SCAN;
        end
      end

      // Sequential leading-one search: one bit per cycle from the MSB.
      S_SCAN: begin
        if (cur_bit) begin
          if (idx_zero) begin
            // Scalar is 1: nothing left to ladder over.
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q - IDXW'(1);
            state_d = S_RST;
          end
        end else if (idx_zero) begin
          zero_key_d = 1'b1;
          state_d    = S_FIN;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end

      // One-cycle core restart; swap value for this step is frozen here.
      S_RST: begin
        swap_d  = cur_bit;
        guard_d = GW'(GUARD);
`ifdef LADDER_WDOG_EN
        wcnt_d  = '0;
`endif
        state_d = S_RUN;
      end

      // Cores run. core_done is ignored for GUARD cycles because a freshly
      // restarted core may still present a stale done through its pc/ROM/IR
      // pipeline.
      S_RUN: begin
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end else if (all_done) begin
          if (idx_zero) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q - IDXW'(1);
            state_d = S_RST;
          end
        end
`ifdef LADDER_WDOG_EN
        // A legitimate step completion takes priority over a timeout on
        // the same cycle.
        if (state_d == S_RUN) begin
          if (wcnt_q == WW'(WDOG_MAX - 1)) begin
            wdog_err_d = 1'b1;
            state_d    = S_FIN;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
`endif
      end

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      zero_key_q <= 1'b0;
      swap_q     <= 1'b0;
      guard_q    <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      zero_key_q <= zero_key_d;
      swap_q     <= swap_d;
      guard_q    <= guard_d;
    end
  end

`ifdef LADDER_WDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Core controls decode straight from the state register so an async reset
  // drops them in the same cycle and holds the cores in restart.
  assign core_rst_n  = (state_q == S_RUN);
  assign core_enable = (state_q == S_RUN);
  assign done        = (state_q == S_FIN);
  assign swap1       = swap_q;
  assign swap2       = swap_q;
  assign bit_idx     = idx_q;
  assign busy        = busy_q;
  assign zero_key    = zero_key_q;

endmodule

// File: tb/tb_ladder_seq.sv
// Directed self-checking bench for ladder_seq with a small per-core model:
// each core counts enabled cycles since its last restart and raises done once
// its programmed delay is reached (or never, when stuck).
module tb_ladder_seq;
  import ecc_pkg::*;

  localparam int KW = 163;
  localparam int NC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] key = '0;
  logic [NC-1:0] core_done;
  logic          core_rst_n, core_enable, swap1, swap2, busy, done, zero_key, wdog_err;
  logic [7:0]    bit_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ladder_seq #(.KW(KW), .NCORES(NC), .GUARD(3), .WDOG_MAX(64)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .core_done(core_done),
    .core_rst_n(core_rst_n), .core_enable(core_enable), .swap1(swap1), .swap2(swap2),
    .bit_idx(bit_idx), .busy(busy), .done(done), .zero_key(zero_key), .wdog_err(wdog_err)
  );

  // ---------------- core model ----------------
  int dly[NC];
  int cnt[NC];
  bit stuck = 1'b0;

  initial for (int i = 0; i < NC; i++) begin dly[i] = 20; cnt[i] = 0; end

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (!core_rst_n) cnt[i] <= 0;
      else if (core_enable) cnt[i] <= cnt[i] + 1;
    end
  end

  always_comb begin
    core_done = '0;
    for (int i = 0; i < NC; i++) core_done[i] = !stuck && (cnt[i] >= dly[i]);
  end

  // ---------------- run monitor results ----------------
  int   nsteps;
  int   step_idx[8];
  logic step_swap[8];
  int   bad_gap, sw_bad, en_seen, done_pulses;

  // Start a job and watch it until done (or the cycle bound expires).
  // n is the number of negedges after the accepting clock edge at which done
  // was first seen; 0 if never. A second start with a different key is
  // injected at cycle mid_at (0 = none).
  task automatic run_key(input logic [KW-1:0] k, input int bound, input int mid_at, output int n);
    logic prev_rn, prev_en, prev_sw;
    int lowlen;
    nsteps = 0; bad_gap = 0; sw_bad = 0; en_seen = 0; done_pulses = 0;
    lowlen = 0; n = 0;
    @(negedge clk);
    key = k;
    start = 1'b1;
    prev_rn = core_rst_n; prev_en = core_enable; prev_sw = swap1;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (mid_at != 0 && c == mid_at) begin start = 1'b1; key = ~k; end
      else if (mid_at != 0 && c == mid_at + 1) start = 1'b0;
      if (core_rst_n && !prev_rn) begin
        if (nsteps > 0 && lowlen != 1) bad_gap++;
        if (nsteps < 8) begin step_idx[nsteps] = int'(bit_idx); step_swap[nsteps] = swap1; end
        nsteps++;
      end
      if (!core_rst_n) lowlen++; else lowlen = 0;
      if (core_enable) en_seen++;
      if (swap1 !== swap2) sw_bad++;
      if (core_enable && prev_en && swap1 !== prev_sw) sw_bad++;
      prev_rn = core_rst_n; prev_en = core_enable; prev_sw = swap1;
      if (done) begin done_pulses++; n = c; break; end
    end
    start = 1'b0;
  endtask

  // Count done pulses over the next cycles after a completion.
  task automatic count_tail(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done) done_pulses++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL reset_core_rst_n got=%b exp=0", core_rst_n); end
    checks++; if (core_enable !== 1'b0) begin failures++; $display("FAIL reset_core_enable got=%b exp=0", core_enable); end
    checks++; if ({busy, done, zero_key, wdog_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, zero_key, wdog_err}); end
    checks++; if (bit_idx !== 8'd0 || swap1 !== 1'b0 || swap2 !== 1'b0) begin failures++; $display("FAIL reset_idx_swap got=%0d/%b%b exp=0/00", bit_idx, swap1, swap2); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || core_rst_n !== 1'b0) begin failures++; $display("FAIL idle_hold got busy=%b rst_n=%b exp=0/0", busy, core_rst_n); end
  endtask

  task automatic test_zero_key();
    int n;
    run_key('0, 400, 0, n);
    // 163 scan cycles then the finishing cycle
    checks++; if (n !== 164) begin failures++; $display("FAIL zero_latency got=%0d exp=164", n); end
    checks++; if (zero_key !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL zero_flags got zk=%b busy=%b exp=1/1", zero_key, busy); end
    checks++; if (nsteps !== 0 || en_seen !== 0) begin failures++; $display("FAIL zero_no_core got steps=%0d en=%0d exp=0/0", nsteps, en_seen); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || zero_key !== 1'b1) begin failures++; $display("FAIL zero_after got done=%b busy=%b zk=%b exp=0/0/1", done, busy, zero_key); end
  endtask

  task automatic test_key_one();
    int n;
    run_key(163'd1, 400, 0, n);
    checks++; if (n !== 164) begin failures++; $display("FAIL one_latency got=%0d exp=164", n); end
    checks++; if (zero_key !== 1'b0) begin failures++; $display("FAIL one_zero_key got=%b exp=0", zero_key); end
    checks++; if (nsteps !== 0 || en_seen !== 0) begin failures++; $display("FAIL one_no_run got steps=%0d en=%0d exp=0/0", nsteps, en_seen); end
  endtask

  task automatic test_three_steps();
    int n;
    int   exp_idx[3];
    logic exp_sw[3];
    exp_idx[0] = 2; exp_idx[1] = 1; exp_idx[2] = 0;
    exp_sw[0] = 1'b0; exp_sw[1] = 1'b1; exp_sw[2] = 1'b1;
    for (int i = 0; i < NC; i++) dly[i] = 20;
    run_key(163'b1011, 600, 0, n);
    // scan idx 162..3 (160) + 3 steps x (1 restart + 21 run) + finish
    checks++; if (n !== 227) begin failures++; $display("FAIL steps_latency got=%0d exp=227", n); end
    checks++; if (nsteps !== 3) begin failures++; $display("FAIL steps_count got=%0d exp=3", nsteps); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (step_idx[i] !== exp_idx[i] || step_swap[i] !== exp_sw[i]) begin
        failures++; $display("FAIL step%0d got idx=%0d swap=%b exp idx=%0d swap=%b", i, step_idx[i], step_swap[i], exp_idx[i], exp_sw[i]);
      end
    end
    checks++; if (bad_gap !== 0 || sw_bad !== 0) begin failures++; $display("FAIL steps_shape got gap=%0d swap=%0d exp=0/0", bad_gap, sw_bad); end
  endtask

  task automatic test_partial_done();
    int n;
    dly[0] = 20; dly[1] = 70; dly[2] = 20;
    run_key(163'b110, 800, 200, n);
    // scan idx 162..2 (161) + 2 steps x (1 + 71) + finish
    checks++; if (n !== 306) begin failures++; $display("FAIL partial_latency got=%0d exp=306", n); end
    checks++; if (nsteps !== 2 || step_swap[0] !== 1'b1 || step_swap[1] !== 1'b0) begin failures++; $display("FAIL partial_steps got n=%0d sw=%b%b exp=2/10", nsteps, step_swap[0], step_swap[1]); end
    count_tail(20);
    checks++; if (done_pulses !== 1) begin failures++; $display("FAIL partial_done_pulses got=%0d exp=1", done_pulses); end
    for (int i = 0; i < NC; i++) dly[i] = 20;
  endtask

  task automatic test_async_reset();
    int n;
    int w;
    key = 163'b1011;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!core_enable && w < 400) begin @(negedge clk); w++; end
    checks++; if (core_enable !== 1'b1) begin failures++; $display("FAIL rst_run_reached got=%b exp=1", core_enable); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (core_enable !== 1'b0 || busy !== 1'b0 || core_rst_n !== 1'b0) begin failures++; $display("FAIL rst_immediate got en=%b busy=%b rst_n=%b exp=0/0/0", core_enable, busy, core_rst_n); end
    checks++; if (bit_idx !== 8'd0 || done !== 1'b0) begin failures++; $display("FAIL rst_idx got idx=%0d done=%b exp=0/0", bit_idx, done); end
    @(negedge clk); rst = 1'b0;
    run_key(163'b11, 600, 0, n);
    // scan idx 162..1 (162) + 1 step (1 + 21) + finish
    checks++; if (n !== 185) begin failures++; $display("FAIL rst_rerun_latency got=%0d exp=185", n); end
    checks++; if (nsteps !== 1 || step_swap[0] !== 1'b1 || zero_key !== 1'b0) begin failures++; $display("FAIL rst_rerun_steps got n=%0d sw=%b zk=%b exp=1/1/0", nsteps, step_swap[0], zero_key); end
  endtask

`ifdef LADDER_WDOG_EN
  task automatic test_wdog();
    int n;
    stuck = 1'b1;
    run_key(163'b10, 600, 0, n);
    // scan idx 162..1 (162) + restart + 64 run cycles + finish
    checks++; if (n !== 228) begin failures++; $display("FAIL wdog_latency got=%0d exp=228", n); end
    checks++; if (wdog_err !== 1'b1) begin failures++; $display("FAIL wdog_err_set got=%b exp=1", wdog_err); end
    stuck = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (wdog_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wdog_sticky got err=%b busy=%b exp=1/0", wdog_err, busy); end
    rst = 1'b1; #1;
    checks++; if (wdog_err !== 1'b0) begin failures++; $display("FAIL wdog_clear got=%b exp=0", wdog_err); end
    @(negedge clk); rst = 1'b0;
  endtask
`else
  task automatic test_no_wdog();
    checks++; if (wdog_err !== 1'b0) begin failures++; $display("FAIL wdog_tied got=%b exp=0", wdog_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_key();
    test_key_one();
    test_three_steps();
    test_partial_done();
    test_async_reset();
`ifdef LADDER_WDOG_EN
    test_wdog();
`else
    test_no_wdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
